// File: rtl/floating_point_multiplier_pipelined.sv
// Three-stage pipelined IEEE-754-style multiplier with valid/ready flow control on both sides.
// Subnormal operands flush to signed zero; every NaN result is the canonical qNaN.
module floating_point_multiplier_pipelined #(
  parameter int unsigned EXPONENT_WIDTH   = 8,
  parameter int unsigned MANTISSA_WIDTH   = 23,
  parameter bit          ROUND_TO_NEAREST = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
);

  localparam int unsigned EW   = EXPONENT_WIDTH;
  localparam int unsigned MW   = MANTISSA_WIDTH;
  localparam int unsigned W    = EW + MW + 1;
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned PW   = 2 * (MW + 1);
  localparam int unsigned BIAS = (2 ** (EW - 1)) - 1;
  localparam int unsigned EMAX = (2 ** EW) - 1;

  // E4M3 has no infinity-free NaN space, so its canonical NaN uses an all-ones mantissa.
  localparam logic [MW-1:0] QNAN_MAN = (EW == 4 && MW == 3) ? {MW{1'b1}}
                                                             : {1'b1, {(MW-1){1'b0}}};
  localparam logic [W-1:0]  QNAN     = {1'b1, {EW{1'b1}}, QNAN_MAN};

  // Operand decode
  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic          a_zero, a_inf, a_nan, a_snan;
  logic          b_zero, b_inf, b_nan, b_snan;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_exp  = a[W-2 -: EW];
  assign b_exp  = b[W-2 -: EW];
  assign a_man  = a[MW-1:0];
  assign b_man  = b[MW-1:0];

  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_man == '0);
  assign b_inf  = (&b_exp) && (b_man == '0);
  assign a_nan  = (&a_exp) && (a_man != '0);
  assign b_nan  = (&b_exp) && (b_man != '0);
  assign a_snan = a_nan && !a_man[MW-1];
  assign b_snan = b_nan && !b_man[MW-1];

  // Handshake: each stage loads when empty or when the stage ahead is draining
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic s1_load, s2_load, s3_load;
  logic s1_en, s2_en, s3_en;

  assign s3_load  = !s3_valid_q || out_ready;
  assign s2_load  = !s2_valid_q || s3_load;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  assign s1_en = s1_load && in_valid;
  assign s2_en = s2_load && s1_valid_q;
  assign s3_en = s3_load && s2_valid_q;

  assign s1_valid_d = s1_load ? in_valid   : s1_valid_q;
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  assign s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;

  // Stage 1: classify, special-case result, mantissa product, biased exponent sum
  logic          s1_sign_q, s1_sign_d;
  logic [XW-1:0] s1_exp_q, s1_exp_d;
  logic [PW-1:0] s1_prod_q, s1_prod_d;
  logic          s1_special_q, s1_special_d;
  logic [W-1:0]  s1_spec_res_q, s1_spec_res_d;
  logic          s1_invalid_q, s1_invalid_d;

  always_comb begin
    s1_sign_d     = a_sign ^ b_sign;
    s1_exp_d      = XW'(a_exp) + XW'(b_exp) - XW'(BIAS);
    s1_prod_d     = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
    s1_special_d  = 1'b0;
    s1_spec_res_d = '0;
    s1_invalid_d  = 1'b0;
    if (a_nan || b_nan) begin
      s1_special_d  = 1'b1;
      s1_spec_res_d = QNAN;
      s1_invalid_d  = a_snan || b_snan;
    end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      s1_special_d  = 1'b1;
      s1_spec_res_d = QNAN;
      s1_invalid_d  = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_special_d  = 1'b1;
      s1_spec_res_d = {s1_sign_d, {EW{1'b1}}, {MW{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_special_d  = 1'b1;
      s1_spec_res_d = {s1_sign_d, {(W-1){1'b0}}};
    end
  end

  // Stage 2: normalize, guard/sticky extraction, range pre-check
  logic          s2_sign_q, s2_sign_d;
  logic [XW-1:0] s2_exp_q, s2_exp_d;
  logic [MW-1:0] s2_frac_q, s2_frac_d;
  logic          s2_guard_q, s2_guard_d;
  logic          s2_sticky_q, s2_sticky_d;
  logic          s2_unf_pre_q, s2_unf_pre_d;
  logic          s2_ovf_pre_q, s2_ovf_pre_d;
  logic          s2_special_q, s2_special_d;
  logic [W-1:0]  s2_spec_res_q, s2_spec_res_d;
  logic          s2_invalid_q, s2_invalid_d;

  always_comb begin
    s2_sign_d     = s1_sign_q;
    s2_special_d  = s1_special_q;
    s2_spec_res_d = s1_spec_res_q;
    s2_invalid_d  = s1_invalid_q;
    s2_exp_d      = s1_exp_q;
    s2_frac_d     = s1_prod_q[2*MW-1 -: MW];
    s2_guard_d    = s1_prod_q[MW-1];
    s2_sticky_d   = |s1_prod_q[MW-2:0];
    if (s1_prod_q[PW-1]) begin
      s2_exp_d    = s1_exp_q + XW'(1);
      s2_frac_d   = s1_prod_q[2*MW -: MW];
      s2_guard_d  = s1_prod_q[MW];
      s2_sticky_d = |s1_prod_q[MW-1:0];
    end
    // Rounding can raise the exponent by at most one, so negative stays underflow.
    s2_unf_pre_d = s2_exp_d[XW-1];
    s2_ovf_pre_d = $signed(s2_exp_d) >= $signed(XW'(EMAX));
  end

  // Stage 3: round, final range check, pack
  logic          round_up;
  logic [MW:0]   frac_sum;
  logic [XW-1:0] exp_f;
  logic          res_unf, res_ovf;
  logic [W-1:0]  out_q, out_d;
  logic          unf_q, unf_d;
  logic          ovf_q, ovf_d;
  logic          inv_q, inv_d;

  always_comb begin
    round_up = ROUND_TO_NEAREST && s2_guard_q && (s2_sticky_q || s2_frac_q[0]);
    frac_sum = {1'b0, s2_frac_q} + (MW+1)'(round_up);
    exp_f    = s2_exp_q + XW'(frac_sum[MW]);
    res_unf  = s2_unf_pre_q || exp_f[XW-1] || (exp_f == '0);
    res_ovf  = s2_ovf_pre_q || ($signed(exp_f) >= $signed(XW'(EMAX)));
    out_d    = {s2_sign_q, exp_f[EW-1:0], frac_sum[MW-1:0]};
    unf_d    = 1'b0;
    ovf_d    = 1'b0;
    inv_d    = 1'b0;
    if (s2_special_q) begin
      out_d = s2_spec_res_q;
      inv_d = s2_invalid_q;
    end else if (res_unf) begin
      out_d = {s2_sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else if (res_ovf) begin
      out_d = {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
      ovf_d = 1'b1;
    end
  end

  // Control state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_q      <= '0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      if (s3_en) begin
        out_q <= out_d;
        unf_q <= unf_d;
        ovf_q <= ovf_d;
        inv_q <= inv_d;
      end
    end
  end

  // Datapath payload registers; qualified by the valid bits so no reset needed
  always_ff @(posedge clk) begin
    if (s1_en) begin
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_prod_q     <= s1_prod_d;
      s1_special_q  <= s1_special_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_invalid_q  <= s1_invalid_d;
    end
    if (s2_en) begin
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_frac_q     <= s2_frac_d;
      s2_guard_q    <= s2_guard_d;
      s2_sticky_q   <= s2_sticky_d;
      s2_unf_pre_q  <= s2_unf_pre_d;
      s2_ovf_pre_q  <= s2_ovf_pre_d;
      s2_special_q  <= s2_special_d;
      s2_spec_res_q <= s2_spec_res_d;
      s2_invalid_q  <= s2_invalid_d;
    end
  end

  assign out_valid              = s3_valid_q;
  assign out                    = out_q;
  assign underflow_flag         = unf_q;
  assign overflow_flag          = ovf_q;
  assign invalid_operation_flag = inv_q;

endmodule

// File: tb/tb_floating_point_multiplier_pipelined.sv
// Scoreboard bench: FP32 round-to-nearest DUT with backpressure and reset,
// plus FP32 round-toward-zero and E4M3 instances driven with single directed operations.
module tb_floating_point_multiplier_pipelined;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_UNF  = 3'b100;
  localparam logic [2:0] F_OVF  = 3'b010;
  localparam logic [2:0] F_INV  = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_s, b_s, out_s;
  logic        unf_s, ovf_s, inv_s;

  logic        rtz_iv, rtz_ir, rtz_ov;
  logic [31:0] rtz_a, rtz_b, rtz_out;
  logic        rtz_unf, rtz_ovf, rtz_inv;

  logic        e4_iv, e4_ir, e4_ov;
  logic [7:0]  e4_a, e4_b, e4_out;
  logic        e4_unf, e4_ovf, e4_inv;

  exp_t        sb[$];
  exp_t        e_mon;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  logic [31:0] held_out;
  logic [2:0]  held_flags;
  bit          held_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  floating_point_multiplier_pipelined #(
    .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1'b1)
  ) u_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_s), .b(b_s), .out_valid(out_valid), .out_ready(out_ready), .out(out_s),
    .underflow_flag(unf_s), .overflow_flag(ovf_s), .invalid_operation_flag(inv_s)
  );

  floating_point_multiplier_pipelined #(
    .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1'b0)
  ) u_rtz (
    .clk(clk), .rst_n(rst_n), .in_valid(rtz_iv), .in_ready(rtz_ir),
    .a(rtz_a), .b(rtz_b), .out_valid(rtz_ov), .out_ready(1'b1), .out(rtz_out),
    .underflow_flag(rtz_unf), .overflow_flag(rtz_ovf), .invalid_operation_flag(rtz_inv)
  );

  floating_point_multiplier_pipelined #(
    .EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .ROUND_TO_NEAREST(1'b1)
  ) u_e4 (
    .clk(clk), .rst_n(rst_n), .in_valid(e4_iv), .in_ready(e4_ir),
    .a(e4_a), .b(e4_b), .out_valid(e4_ov), .out_ready(1'b1), .out(e4_out),
    .underflow_flag(e4_unf), .overflow_flag(e4_ovf), .invalid_operation_flag(e4_inv)
  );

  task automatic do_check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks hold-while-stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        if (held_v) begin
          do_check("stall_out", out_s, held_out);
          do_check("stall_flags", 32'({unf_s, ovf_s, inv_s}), 32'(held_flags));
        end
        held_v     = 1'b1;
        held_out   = out_s;
        held_flags = {unf_s, ovf_s, inv_s};
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("spurious_result: got 0x%08h with nothing expected", out_s));
        end else begin
          e_mon = sb.pop_front();
          do_check("result", out_s, e_mon.res);
          do_check("flags", 32'({unf_s, ovf_s, inv_s}), 32'(e_mon.flags));
          if (e_mon.chk_lat) do_check("latency", 32'(cyc - e_mon.acc_cyc), 32'd3);
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Presents one operation; call just after a rising edge, returns just after the accepting edge
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] rv,
                       input logic [2:0] fv, input bit lat);
    exp_t e;
    int   waited;
    a_s      = av;
    b_s      = bv;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now($sformatf("accept_timeout: in_ready stuck at 0 for 0x%08h", av));
    end else begin
      e.res     = rv;
      e.flags   = fv;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_now($sformatf("drain_timeout: %0d results never emerged", sb.size()));
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_rtz(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] rv);
    int acc;
    bit got;
    rtz_a  = av;
    rtz_b  = bv;
    rtz_iv = 1'b1;
    @(negedge clk);
    do_check("rtz_in_ready", 32'(rtz_ir), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    rtz_iv = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (rtz_ov) begin
        do_check("rtz_result", rtz_out, rv);
        do_check("rtz_flags", 32'({rtz_unf, rtz_ovf, rtz_inv}), 32'd0);
        do_check("rtz_latency", 32'(cyc - acc), 32'd3);
        got = 1'b1;
      end
    end
    if (!got) fail_now("rtz_timeout: out_valid never rose");
    @(posedge clk);
    #1;
  endtask

  task automatic run_e4(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] rv,
                        input logic [2:0] fv);
    bit got;
    e4_a  = av;
    e4_b  = bv;
    e4_iv = 1'b1;
    @(negedge clk);
    do_check("e4_in_ready", 32'(e4_ir), 32'd1);
    @(posedge clk);
    #1;
    e4_iv = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (e4_ov) begin
        do_check("e4_result", 32'(e4_out), 32'(rv));
        do_check("e4_flags", 32'({e4_unf, e4_ovf, e4_inv}), 32'(fv));
        got = 1'b1;
      end
    end
    if (!got) fail_now("e4_timeout: out_valid never rose");
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_s = '0;  b_s = '0;
    rtz_iv = 1'b0; rtz_a = '0; rtz_b = '0;
    e4_iv  = 1'b0; e4_a  = '0; e4_b  = '0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_check("rst_out_valid", 32'(out_valid), 32'd0);
    do_check("rst_in_ready", 32'(in_ready), 32'd1);
    do_check("rst_out", out_s, 32'd0);
    do_check("rst_flags", 32'({unf_s, ovf_s, inv_s}), 32'd0);

    // Back-to-back directed vectors with the consumer always ready
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, F_NONE, 1'b1);
    issue(32'h3FC00001, 32'h3FC00001, 32'h40100002, F_NONE, 1'b1);
    issue(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, F_NONE, 1'b1);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, F_OVF,  1'b1);
    issue(32'h7F000001, 32'h3FFFFFFE, 32'h7F800000, F_OVF,  1'b1);
    issue(32'h00800000, 32'h00800000, 32'h00000000, F_UNF,  1'b1);
    issue(32'h3F000000, 32'h00800000, 32'h00000000, F_UNF,  1'b1);
    issue(32'h3F800000, 32'h00800000, 32'h00800000, F_NONE, 1'b1);
    issue(32'h80000000, 32'h7F800000, 32'hFFC00000, F_INV,  1'b1);
    issue(32'h7FC00000, 32'h3F800000, 32'hFFC00000, F_NONE, 1'b1);
    issue(32'h7F800001, 32'h3F800000, 32'hFFC00000, F_INV,  1'b1);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, 1'b1);
    issue(32'h7F800000, 32'hFF800000, 32'hFF800000, F_NONE, 1'b1);
    issue(32'h80400000, 32'h3F800000, 32'h80000000, F_NONE, 1'b1);
    issue(32'hC0000000, 32'h40400000, 32'hC0C00000, F_NONE, 1'b1);
    wait_drain();

    // Backpressure: three fill the pipe, the fourth must wait
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE, 1'b0);
    issue(32'h40000000, 32'h40000000, 32'h40800000, F_NONE, 1'b0);
    issue(32'h40400000, 32'h40000000, 32'h40C00000, F_NONE, 1'b0);
    a_s = 32'h3FC00000;
    b_s = 32'h3FC00000;
    in_valid = 1'b1;
    @(negedge clk);
    do_check("in_ready_full", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    do_check("in_ready_stalled", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE, 1'b0);
    issue(32'h40800000, 32'h3F000000, 32'h40000000, F_NONE, 1'b0);
    wait_drain();

    // Reset with two operations in flight, the older one already presented
    issue(32'h3F800000, 32'h40000000, 32'h40000000, F_NONE, 1'b1);
    issue(32'h40000000, 32'h40400000, 32'h40C00000, F_NONE, 1'b1);
    @(posedge clk);
    #1;
    do_check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    do_check("reset_async_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_check("rel_out_valid", 32'(out_valid), 32'd0);
    do_check("rel_out", out_s, 32'd0);
    do_check("rel_flags", 32'({unf_s, ovf_s, inv_s}), 32'd0);
    do_check("rel_in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE, 1'b1);
    wait_drain();

    // Round toward zero build
    run_rtz(32'h3FC00001, 32'h3FC00001, 32'h40100001);
    run_rtz(32'h3F800001, 32'h3FFFFFFE, 32'h3FFFFFFF);
    run_rtz(32'h3FC00000, 32'h40000000, 32'h40400000);

    // E4M3 build
    run_e4(8'h7F, 8'h38, 8'hFF, F_NONE);
    run_e4(8'h79, 8'h38, 8'hFF, F_INV);
    run_e4(8'h38, 8'h40, 8'h40, F_NONE);
    run_e4(8'h77, 8'h77, 8'h78, F_OVF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
